// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
//   Shared definitions for the 7-segment capture block.
//
//   Pattern byte layout on the wire, per digit: [7:0] = {c,dp,b,a,d,e,f,g}.
//   The decoder works on a compacted 7-bit code with the dp bit removed:
//     code[6:0] = {c,b,a,d,e,f,g}
//
//   Contents:
//     SEG_*          bit index of each segment inside the pattern byte
//     digit_state_t  per-digit FSM states
//     seg_kind_t     classification of a segment pattern
//     seg_decode_t   decoder result {kind, value}
//     seg7_compact() strips dp and packs the seven segments into a code
//     seg7_decode()  maps a 7-bit code to {kind, hex value}
// ---------------------------------------------------------------------------
package seg7_pkg;

    localparam int SEG_G  = 0;
    localparam int SEG_F  = 1;
    localparam int SEG_E  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_A  = 4;
    localparam int SEG_B  = 5;
    localparam int SEG_DP = 6;
    localparam int SEG_C  = 7;

    localparam int SEG_BITS   = 8;   // pattern byte width per digit
    localparam int VALUE_BITS = 4;   // hex nibble width per digit

    typedef enum logic {
        SETTLING = 1'b0,
        LOCKED   = 1'b1
    } digit_state_t;

    typedef enum logic [1:0] {
        HEX     = 2'd0,
        BLANK   = 2'd1,
        ILLEGAL = 2'd2
    } seg_kind_t;

    typedef struct packed {
        seg_kind_t       kind;
        logic [3:0]      value;
    } seg_decode_t;

    // Drop dp and reorder the remaining segments into {c,b,a,d,e,f,g}.
    function automatic logic [6:0] seg7_compact(input logic [7:0] pattern);
        return {pattern[SEG_C], pattern[SEG_B], pattern[SEG_A], pattern[SEG_D],
                pattern[SEG_E], pattern[SEG_F], pattern[SEG_G]};
    endfunction

    // Code bits are {c,b,a,d,e,f,g}; each constant below lists the lit
    // segments of the hex glyph it represents.
    function automatic seg_decode_t seg7_decode(input logic [6:0] code);
        seg_decode_t result;
        result.kind  = HEX;
        result.value = 4'h0;
        case (code)
            7'h7E:   result.value = 4'h0;   // a b c d e f
            7'h60:   result.value = 4'h1;   // b c
            7'h3D:   result.value = 4'h2;   // a b d e g
            7'h79:   result.value = 4'h3;   // a b c d g
            7'h63:   result.value = 4'h4;   // b c f g
            7'h5B:   result.value = 4'h5;   // a c d f g
            7'h5F:   result.value = 4'h6;   // a c d e f g
            7'h70:   result.value = 4'h7;   // a b c
            7'h7F:   result.value = 4'h8;   // a b c d e f g
            7'h7B:   result.value = 4'h9;   // a b c d f g
            7'h77:   result.value = 4'hA;   // a b c e f g
            7'h4F:   result.value = 4'hB;   // c d e f g
            7'h1E:   result.value = 4'hC;   // a d e f
            7'h6D:   result.value = 4'hD;   // b c d e g
            7'h1F:   result.value = 4'hE;   // a d e f g
            7'h17:   result.value = 4'hF;   // a e f g
            7'h00:   result.kind  = BLANK;
            default: result.kind  = ILLEGAL;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/seg7_capture_digit.sv
// ---------------------------------------------------------------------------
// seg7_capture_digit
//   Captures one 7-segment digit: 2-flop synchroniser, stability counter,
//   SETTLING/LOCKED FSM and registered decode outputs.
//
//   Parameters:
//     STABLE_CYCLES  consecutive identical synced samples needed to commit
//
//   Ports:
//     input_clock    in   1  rising-edge clock
//     input_reset_n  in   1  asynchronous active-low reset
//     seg_in         in   8  {c,dp,b,a,d,e,f,g}, asynchronous to the clock
//     digit_value    out  4  last committed hex value
//     digit_dp       out  1  last committed dp bit
//     digit_valid    out  1  locked on a legal hex pattern
//     digit_blank    out  1  locked on all segments off
//     digit_error    out  1  locked on a pattern that is neither hex nor blank
//     update_pulse   out  1  one cycle when a commit changes the result tuple
// ---------------------------------------------------------------------------
module seg7_capture_digit
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  input_clock,
    input  logic                  input_reset_n,
    input  logic [SEG_BITS-1:0]   seg_in,
    output logic [VALUE_BITS-1:0] digit_value,
    output logic                  digit_dp,
    output logic                  digit_valid,
    output logic                  digit_blank,
    output logic                  digit_error,
    output logic                  update_pulse
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(STABLE_CYCLES);

    logic [SEG_BITS-1:0]   sync1;
    logic [SEG_BITS-1:0]   sync2;
    logic [SEG_BITS-1:0]   prev;
    logic [CNT_W-1:0]      cnt;
    digit_state_t          state;
    // Kind of the most recent commit. The flags clear while settling, so the
    // change detector needs its own copy of what was last committed.
    seg_kind_t             last_kind;

    logic [CNT_W-1:0]      cnt_nxt;
    digit_state_t          state_nxt;
    seg_kind_t             kind_nxt;
    logic [VALUE_BITS-1:0] value_nxt;
    logic [VALUE_BITS-1:0] commit_value;
    logic                  dp_nxt;
    logic                  valid_nxt;
    logic                  blank_nxt;
    logic                  error_nxt;
    logic                  pulse_nxt;

    logic                  pattern_same;
    seg_decode_t           dec;

    assign pattern_same = (sync2 == prev);
    assign dec          = seg7_decode(seg7_compact(sync2));

    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        kind_nxt     = last_kind;
        value_nxt    = digit_value;
        dp_nxt       = digit_dp;
        valid_nxt    = digit_valid;
        blank_nxt    = digit_blank;
        error_nxt    = digit_error;
        pulse_nxt    = 1'b0;
        commit_value = digit_value;

        case (state)
            SETTLING: begin
                if (!pattern_same) begin
                    cnt_nxt = '0;
                end else begin
                    if (cnt != CNT_SAT) begin
                        cnt_nxt = cnt + 1'b1;
                    end
                    if (cnt == CNT_LAST) begin
                        state_nxt = LOCKED;
                        case (dec.kind)
                            HEX:     commit_value = dec.value;
                            BLANK:   commit_value = '0;
                            default: commit_value = digit_value;  // illegal keeps the old value
                        endcase
                        value_nxt = commit_value;
                        dp_nxt    = sync2[SEG_DP];
                        valid_nxt = (dec.kind == HEX);
                        blank_nxt = (dec.kind == BLANK);
                        error_nxt = (dec.kind == ILLEGAL);
                        kind_nxt  = dec.kind;
                        pulse_nxt = ({commit_value, sync2[SEG_DP], dec.kind}
                                     != {digit_value, digit_dp, last_kind});
                    end
                end
            end
            LOCKED: begin
                if (!pattern_same) begin
                    state_nxt = SETTLING;
                    cnt_nxt   = '0;
                    valid_nxt = 1'b0;
                    blank_nxt = 1'b0;
                    error_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = SETTLING;
                cnt_nxt   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge input_clock or negedge input_reset_n) begin
        if (!input_reset_n) begin
            sync1        <= '0;
            sync2        <= '0;
            prev         <= '0;
            cnt          <= '0;
            state        <= SETTLING;
            // Power-up is treated as a blank commit, so a first commit of a
            // blank pattern produces no update pulse.
            last_kind    <= BLANK;
            digit_value  <= '0;
            digit_dp     <= 1'b0;
            digit_valid  <= 1'b0;
            digit_blank  <= 1'b0;
            digit_error  <= 1'b0;
            update_pulse <= 1'b0;
        end else begin
            sync1        <= seg_in;
            sync2        <= sync1;
            prev         <= sync2;
            cnt          <= cnt_nxt;
            state        <= state_nxt;
            last_kind    <= kind_nxt;
            digit_value  <= value_nxt;
            digit_dp     <= dp_nxt;
            digit_valid  <= valid_nxt;
            digit_blank  <= blank_nxt;
            digit_error  <= error_nxt;
            update_pulse <= pulse_nxt;
        end
    end

endmodule

// File: rtl/seg7_capture.sv
// ---------------------------------------------------------------------------
// seg7_capture
//   Reads driven 7-segment lines back into hex nibbles. Each digit is
//   synchronised, debounced until stable and decoded; blank and illegal
//   patterns are flagged. Digits are fully independent.
//
//   Parameters:
//     NUM_DIGITS     number of digits captured (1..8)
//     STABLE_CYCLES  consecutive identical synced samples to commit (>=1)
//
//   Ports:
//     input_clock    in   1             rising-edge clock
//     input_reset_n  in   1             asynchronous active-low reset
//     seg_in         in   8*NUM_DIGITS  per digit {c,dp,b,a,d,e,f,g}
//     digit_value    out  4*NUM_DIGITS  last committed hex value per digit
//     digit_dp       out  NUM_DIGITS    last committed dp per digit
//     digit_valid    out  NUM_DIGITS    locked on a legal hex pattern
//     digit_blank    out  NUM_DIGITS    locked on all segments off
//     digit_error    out  NUM_DIGITS    locked on an illegal pattern
//     update_pulse   out  NUM_DIGITS    one-cycle pulse on a changed commit
// ---------------------------------------------------------------------------
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 3,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                           input_clock,
    input  logic                           input_reset_n,
    input  logic [SEG_BITS*NUM_DIGITS-1:0]   seg_in,
    output logic [VALUE_BITS*NUM_DIGITS-1:0] digit_value,
    output logic [NUM_DIGITS-1:0]          digit_dp,
    output logic [NUM_DIGITS-1:0]          digit_valid,
    output logic [NUM_DIGITS-1:0]          digit_blank,
    output logic [NUM_DIGITS-1:0]          digit_error,
    output logic [NUM_DIGITS-1:0]          update_pulse
);

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        seg7_capture_digit #(
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_digit (
            .input_clock   (input_clock),
            .input_reset_n (input_reset_n),
            .seg_in        (seg_in[SEG_BITS*i +: SEG_BITS]),
            .digit_value   (digit_value[VALUE_BITS*i +: VALUE_BITS]),
            .digit_dp      (digit_dp[i]),
            .digit_valid   (digit_valid[i]),
            .digit_blank   (digit_blank[i]),
            .digit_error   (digit_error[i]),
            .update_pulse  (update_pulse[i])
        );
    end

endmodule

// File: tb/tb_seg7_capture.sv
// ---------------------------------------------------------------------------
// tb_seg7_capture
//   Directed bench for seg7_capture (3 digits, STABLE_CYCLES=4). Expected
//   commits are queued when a pattern is driven and checked when the commit
//   cycle arrives, together with the cycle before (still settling) and the
//   cycle after (pulse gone).
// ---------------------------------------------------------------------------
module tb_seg7_capture;

    localparam int ND  = 3;
    localparam int SC  = 4;
    // Driven at a falling edge: sampled at the next rising edge k, committed
    // at edge k+2+SC, i.e. SC+3 rising edges after the drive point.
    localparam int LAT = SC + 3;

    localparam logic [2:0] F_VALID = 3'b100;
    localparam logic [2:0] F_BLANK = 3'b010;
    localparam logic [2:0] F_ERROR = 3'b001;

    logic              input_clock   = 1'b0;
    logic              input_reset_n = 1'b0;
    logic [8*ND-1:0]   seg_in        = '0;
    logic [4*ND-1:0]   digit_value;
    logic [ND-1:0]     digit_dp;
    logic [ND-1:0]     digit_valid;
    logic [ND-1:0]     digit_blank;
    logic [ND-1:0]     digit_error;
    logic [ND-1:0]     update_pulse;

    seg7_capture #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (SC)
    ) dut (
        .input_clock   (input_clock),
        .input_reset_n (input_reset_n),
        .seg_in        (seg_in),
        .digit_value   (digit_value),
        .digit_dp      (digit_dp),
        .digit_valid   (digit_valid),
        .digit_blank   (digit_blank),
        .digit_error   (digit_error),
        .update_pulse  (update_pulse)
    );

    always #5 input_clock = ~input_clock;

    int cyc = 0;
    always @(posedge input_clock) cyc <= cyc + 1;

    typedef struct {
        int         at;
        int         d;
        logic [3:0] v;
        logic       dp;
        logic [2:0] f;      // {valid, blank, error}
        logic       pulse;
        logic       post;   // entry is the one-cycle-later pulse-off check
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic logic [2:0] flags_of(input int d);
        return {digit_valid[d], digit_blank[d], digit_error[d]};
    endfunction

    task automatic drive(input int d, input logic [7:0] pattern);
        seg_in[8*d +: 8] = pattern;
    endtask

    task automatic expect_commit(input int d, input logic [3:0] v, input logic dp,
                                 input logic [2:0] f, input logic pulse, input int lat);
        exp_t e;
        e.at = cyc + lat; e.d = d; e.v = v; e.dp = dp; e.f = f; e.pulse = pulse; e.post = 1'b0;
        sb.push_back(e);
    endtask

    // Advance to the next falling edge and service every due scoreboard entry.
    task automatic step();
        exp_t keep[$];
        exp_t e;
        @(negedge input_clock);
        keep = {};
        foreach (sb[i]) begin
            e = sb[i];
            if (!e.post && e.at - 1 == cyc) begin
                check($sformatf("d%0d_pre_flags@%0d", e.d, cyc), 32'(flags_of(e.d)), 32'(3'b000));
                keep.push_back(e);
            end else if (e.at == cyc && !e.post) begin
                check($sformatf("d%0d_value@%0d", e.d, cyc), 32'(digit_value[4*e.d +: 4]), 32'(e.v));
                check($sformatf("d%0d_dp@%0d", e.d, cyc), 32'(digit_dp[e.d]), 32'(e.dp));
                check($sformatf("d%0d_flags@%0d", e.d, cyc), 32'(flags_of(e.d)), 32'(e.f));
                check($sformatf("d%0d_pulse@%0d", e.d, cyc), 32'(update_pulse[e.d]), 32'(e.pulse));
                e.at = cyc + 1;
                e.post = 1'b1;
                keep.push_back(e);
            end else if (e.post && e.at == cyc) begin
                check($sformatf("d%0d_pulse_off@%0d", e.d, cyc), 32'(update_pulse[e.d]), 32'(1'b0));
            end else begin
                keep.push_back(e);
            end
        end
        sb = keep;
    endtask

    task automatic wait_drain(input int max_cycles);
        int n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            step();
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb = {};
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] tog;
        int         t6_start;

        // Reset state.
        repeat (2) @(negedge input_clock);
        check("rst_value", 32'(digit_value), 32'd0);
        check("rst_dp",    32'(digit_dp),    32'd0);
        check("rst_flags", 32'({digit_valid, digit_blank, digit_error}), 32'd0);
        check("rst_pulse", 32'(update_pulse), 32'd0);

        // Idle inputs settle to blank without an update pulse.
        input_reset_n = 1'b1;
        for (int d = 0; d < ND; d++) expect_commit(d, 4'h0, 1'b0, F_BLANK, 1'b0, 4);
        wait_drain(20);

        // 1: "5" on digit 0.
        drive(0, 8'h9B);
        expect_commit(0, 4'h5, 1'b0, F_VALID, 1'b1, LAT);
        wait_drain(20);

        // 2: two-cycle glitch to "8", back to "5": recommit with no pulse.
        drive(0, 8'hBF);
        step();
        step();
        drive(0, 8'h9B);
        expect_commit(0, 4'h5, 1'b0, F_VALID, 1'b0, LAT);
        step();
        check("t2_valid_dropped", 32'(digit_valid[0]), 32'd0);
        check("t2_value_held",    32'(digit_value[3:0]), 32'h5);
        wait_drain(20);

        // 3: illegal (a only) keeps the value, then blank clears it.
        drive(0, 8'h10);
        expect_commit(0, 4'h5, 1'b0, F_ERROR, 1'b1, LAT);
        wait_drain(20);
        drive(0, 8'h00);
        expect_commit(0, 4'h0, 1'b0, F_BLANK, 1'b1, LAT);
        wait_drain(20);

        // 4: simultaneous commits on digits 1 and 2.
        drive(1, 8'hA0);
        drive(2, 8'hFF);
        expect_commit(1, 4'h1, 1'b0, F_VALID, 1'b1, LAT);
        expect_commit(2, 4'h8, 1'b1, F_VALID, 1'b1, LAT);
        repeat (LAT) step();
        check("t4_pulse_vec", 32'(update_pulse), 32'(3'b110));
        wait_drain(20);

        // 5: asynchronous reset two cycles into settling, then full latency.
        drive(0, 8'hBF);
        step();
        step();
        input_reset_n = 1'b0;
        #1;
        check("t5_rst_value", 32'(digit_value), 32'd0);
        check("t5_rst_dp",    32'(digit_dp),    32'd0);
        check("t5_rst_flags", 32'({digit_valid, digit_blank, digit_error}), 32'd0);
        check("t5_rst_pulse", 32'(update_pulse), 32'd0);
        step();
        step();
        input_reset_n = 1'b1;
        expect_commit(0, 4'h8, 1'b0, F_VALID, 1'b1, LAT);
        expect_commit(1, 4'h1, 1'b0, F_VALID, 1'b1, LAT);
        expect_commit(2, 4'h8, 1'b1, F_VALID, 1'b1, LAT);
        wait_drain(20);

        // 6: segment g toggles every 3 cycles: never commits.
        t6_start = cyc;
        tog = 8'hBE;
        for (int i = 0; i < 16; i++) begin
            drive(0, tog);
            tog = tog ^ 8'h01;
            repeat (3) begin
                step();
                if (cyc >= t6_start + 3) begin
                    check($sformatf("t6_quiet@%0d", cyc),
                          32'({flags_of(0), update_pulse[0]}), 32'd0);
                end
            end
        end
        check("t6_value_held", 32'(digit_value[3:0]), 32'h8);
        // Holding g off ("0") finally commits.
        drive(0, 8'hBE);
        expect_commit(0, 4'h0, 1'b0, F_VALID, 1'b1, LAT);
        wait_drain(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
